// File: rtl/pwm_pkg.sv
// Shared PWM definitions: measurement FSM states and counter ceiling helper.
// Reusable by the generator side.
package pwm_pkg;

    typedef enum logic [0:0] {
        IDLE,
        MEAS
    } pwm_state_e;

    // Largest value a width-bit counter may reach before it is declared stuck.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_det.sv
// Synchroniser, optional 3-tap majority glitch filter and edge detection for the PWM input.
// Optional filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Any single-cycle excursion never holds two of the three taps, so it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= s;
        end
    end

    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with one-cycle result strobe and stuck-input overflow report.
// Optional input glitch filter (inside pwm_edge_det) enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] cap_period,
    output logic [WIDTH-1:0] cap_high,
    output logic             cap_ovf,
    output logic             cap_level,
    output logic             cap_stb
);

    localparam logic [WIDTH-1:0] CntMax = WIDTH'(cnt_max(WIDTH));
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic s;
    logic rise;
    logic edge_fall_unused;

    pwm_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (edge_fall_unused)
    );

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] cap_period_d;
    logic [WIDTH-1:0] cap_high_d;
    logic             cap_ovf_d;
    logic             cap_level_d;
    logic             cap_stb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            cap_period   <= '0;
            cap_high     <= '0;
            cap_ovf      <= 1'b0;
            cap_level    <= 1'b0;
            cap_stb      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            cap_period   <= cap_period_d;
            cap_high     <= cap_high_d;
            cap_ovf      <= cap_ovf_d;
            cap_level    <= cap_level_d;
            cap_stb      <= cap_stb_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        cap_period_d = cap_period;
        cap_high_d   = cap_high;
        cap_ovf_d    = cap_ovf;
        cap_level_d  = cap_level;
        cap_stb_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                period_cnt_d = '0;
                high_cnt_d   = '0;
                // The first edge only arms; there is no complete period to report yet.
                if (rise) begin
                    period_cnt_d = CntOne;
                    high_cnt_d   = CntOne;
                    state_d      = MEAS;
                end
            end

            MEAS: begin
                if (rise) begin
                    cap_period_d = period_cnt_q;
                    cap_high_d   = high_cnt_q;
                    cap_ovf_d    = 1'b0;
                    cap_level_d  = 1'b1;
                    cap_stb_d    = 1'b1;
                    period_cnt_d = CntOne;
                    high_cnt_d   = CntOne;
                end else if (period_cnt_q == CntMax) begin
                    cap_period_d = CntMax;
                    cap_high_d   = high_cnt_q;
                    cap_ovf_d    = 1'b1;
                    cap_level_d  = s;
                    cap_stb_d    = 1'b1;
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    state_d      = IDLE;
                end else begin
                    period_cnt_d = period_cnt_q + CntOne;
                    high_cnt_d   = high_cnt_q + WIDTH'(s);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
